mem_resp_stage: RTL

//  Parametrised MEM pipeline stage for a variable-latency data bus (req/addr_ok/data_ok).

---
 rtl/mem_pkg.sv | 23 ++
 rtl/load_ext.sv | 33 +++
 rtl/mem_resp_stage.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared load-op encoding and helpers for the MEM stage.
// Holds the ld_op_e enum and the byte-offset width function.
package mem_pkg;

  localparam int LD_OP_W = 3;

  typedef enum logic [LD_OP_W-1:0] {
    LD_NONE = 3'd0,
    LD_B    = 3'd1,
    LD_BU   = 3'd2,
    LD_H    = 3'd3,
    LD_HU   = 3'd4,
    LD_W    = 3'd5,
    LD_WU   = 3'd6,
    LD_D    = 3'd7
  } ld_op_e;

  // Bits of the address that select a byte within one XLEN word.
  function automatic int ld_offset_w(input int xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/load_ext.sv
// load_ext: aligns bus read data by byte offset and sign/zero extends.
// Ports: data/offset/ld_op in, result out (combinational).
module load_ext
  import mem_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = ld_offset_w(XLEN)
) (
  input  logic [XLEN-1:0]  data,
  input  logic [OFF_W-1:0] offset,
  input  ld_op_e           ld_op,
  output logic [XLEN-1:0]  result
);

  logic [XLEN-1:0] sh;

  assign sh = data >> {offset, 3'b000};

  // Size casts of signed operands sign-extend to XLEN.
  always_comb begin
    result = sh;
    unique case (ld_op)
      LD_B:    result = XLEN'($signed(sh[7:0]));
      LD_BU:   result = XLEN'(sh[7:0]);
      LD_H:    result = XLEN'($signed(sh[15:0]));
      LD_HU:   result = XLEN'(sh[15:0]);
      LD_W:    result = XLEN'($signed(sh[31:0]));
      LD_WU:   result = XLEN'(sh[31:0]);
      default: result = sh;
    endcase
  end

endmodule

// File: rtl/mem_resp_stage.sv
// mem_resp_stage: MEM stage holding one EX instruction until its
// bus data_ok arrives; extends load data, feeds WB and the ID bypass.
// Ports: in_* from EX (valid/allowin), out_* to WB (valid/allowin),
// flush from WB, data_ok/rdata from the bus, fwd_* and mem_excp
// toward ID/EX. Responses of flushed requests are counted and dropped.
module mem_resp_stage
  import mem_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RF_AW    = 5,
  parameter int MAX_OUTS = 2,
  parameter int SIDE_W   = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_allowin,
  input  logic [31:0]       in_pc,
  input  logic              in_rf_we,
  input  logic [RF_AW-1:0]  in_rf_waddr,
  input  logic [XLEN-1:0]   in_result,
  input  logic [2:0]        in_ld_op,
  input  logic              in_req_sent,
  input  logic              in_excp,
  input  logic [SIDE_W-1:0] in_side,
  input  logic              flush,
  input  logic              data_ok,
  input  logic [XLEN-1:0]   rdata,
  output logic              out_valid,
  input  logic              out_allowin,
  output logic [31:0]       out_pc,
  output logic              out_rf_we,
  output logic [RF_AW-1:0]  out_rf_waddr,
  output logic [XLEN-1:0]   out_rf_wdata,
  output logic [SIDE_W-1:0] out_side,
  output logic              fwd_we,
  output logic              fwd_pending,
  output logic              mem_excp
);

  localparam int OFF_W = ld_offset_w(XLEN);
  localparam int CNT_W = $clog2(MAX_OUTS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTS);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("mem_resp_stage: XLEN must be 32 or 64");
  end

  logic              valid;
  logic [31:0]       pc_q;
  logic              rf_we_q;
  logic [RF_AW-1:0]  waddr_q;
  logic [XLEN-1:0]   result_q;
  ld_op_e            ld_op_q;
  logic              req_q;
  logic              excp_q;
  logic [SIDE_W-1:0] side_q;

  logic              buf_valid;
  logic [XLEN-1:0]   rdata_buf;
  logic [CNT_W-1:0]  cancel_cnt;

  logic              cnt_zero;
  logic              wait_resp;
  logic              owned_ok;
  logic              ready_go;
  logic              leave;
  logic              accept;
  logic              cnt_inc;
  logic              cnt_dec;
  logic              buf_load;

  logic [XLEN-1:0]   ld_src;
  logic [XLEN-1:0]   ld_val;

  // A response belongs to the resident instruction only once every
  // response of a flushed predecessor has been drained.
  assign cnt_zero  = (cancel_cnt == '0);
  assign wait_resp = valid & req_q & ~buf_valid;
  assign owned_ok  = data_ok & cnt_zero & wait_resp;
  assign ready_go  = ~wait_resp | (data_ok & cnt_zero);

  assign in_allowin = ~valid | (ready_go & out_allowin) | flush;
  assign out_valid  = valid & ready_go & ~flush;

  assign leave    = flush | (out_valid & out_allowin);
  assign accept   = in_valid & in_allowin;
  assign buf_load = owned_ok & ~out_allowin;

  // A flushed waiter leaves its response in flight unless it lands now.
  assign cnt_dec = data_ok & ~cnt_zero;
  assign cnt_inc = flush & wait_resp & ~owned_ok;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid      <= 1'b0;
      buf_valid  <= 1'b0;
      cancel_cnt <= '0;
      rf_we_q    <= 1'b0;
      req_q      <= 1'b0;
      excp_q     <= 1'b0;
    end else begin
      if (in_allowin) valid <= in_valid;
      if (buf_load) buf_valid <= 1'b1;
      if (leave) buf_valid <= 1'b0;
      unique case ({cnt_inc, cnt_dec})
        2'b10:   cancel_cnt <= cancel_cnt + CNT_ONE;
        2'b01:   cancel_cnt <= cancel_cnt - CNT_ONE;
        default: cancel_cnt <= cancel_cnt;
      endcase
      if (accept) begin
        rf_we_q <= in_rf_we;
        req_q   <= in_req_sent;
        excp_q  <= in_excp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pc_q     <= in_pc;
      waddr_q  <= in_rf_waddr;
      result_q <= in_result;
      ld_op_q  <= ld_op_e'(in_ld_op);
      side_q   <= in_side;
    end
    if (buf_load) rdata_buf <= rdata;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (resetn && cnt_inc && !cnt_dec)
      assert (cancel_cnt != CNT_MAX);
  end
`endif

  assign ld_src = buf_valid ? rdata_buf : rdata;

  load_ext #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_load_ext (
    .data   (ld_src),
    .offset (result_q[OFF_W-1:0]),
    .ld_op  (ld_op_q),
    .result (ld_val)
  );

  assign out_pc       = pc_q;
  assign out_rf_we    = valid & rf_we_q & ~excp_q;
  assign out_rf_waddr = waddr_q;
  assign out_rf_wdata = (ld_op_q == LD_NONE) ? result_q : ld_val;
  assign out_side     = side_q;

  assign fwd_we      = valid & rf_we_q;
  assign fwd_pending = valid & (ld_op_q != LD_NONE) & ~ready_go;
  assign mem_excp    = valid & excp_q;

endmodule
